fetch_unit: RTL
===============

# fetch_unit

Pipeline fetch stage of the five-stage MIPS core: holds the program counter, selects the next PC (sequential, branch, jump, jump-register), presents the fetch address to instruction memory and registers the fetched word into the F/D pipeline register. It sits directly upstream of decode. The registered `D_instr[15:0]` is the 16-bit immediate consumed by the immediate extender, and `D_instr[25:0]` supplies the jump index. Branch delay slots are architectural; this block never squashes the delay-slot instruction.

## Interface
- `PC_RESET`, 32'h0000_3000, PC value loaded on reset.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; forces all registers to reset values immediately.
- `stall`  in  1  from the hazard unit; freezes the PC and the F/D register.
- `npc_sel`  in  2  from the D-stage controller, decoded from `D_instr`: 00 seq, 01 branch, 10 j/jal, 11 jr/jalr.
- `branch_taken`  in  1  D-stage compare result; meaningful only when `npc_sel`=01.
- `jr_target`  in  32  forwarded rs value for jr/jalr.
- `F_instr`  in  32  instruction word from IM, combinational on `im_addr`.
- `im_addr`  out  32  equals `F_pc`.
- `F_pc`  out  32  current fetch PC.
- `D_instr`  out  32  F/D instruction register.
- `D_pc`  out  32  F/D PC register.
- `D_pc8`  out  32  `D_pc + 8`, combinational, used as the link address for jal/jalr.

## Operation
- Targets are computed from D-stage state:
  - seq = `F_pc + 4`
  - branch = `D_pc + 4 + {{14{D_instr[15]}}, D_instr[15:0], 2'b00}`
  - jump = `{D_pc[31:28], D_instr[25:0], 2'b00}` (upper bits are taken from `D_pc + 4`; they are identical except at a 256 MB boundary, where `D_pc + 4` governs)
  - jr = `{jr_target[31:2], 2'b00}`; low two bits are ignored and no alignment exception is raised.
- Next PC:
  - `npc_sel`=00 → seq.
  - `npc_sel`=01 → branch if `branch_taken`, else seq.
  - `npc_sel`=10 → jump.
  - `npc_sel`=11 → jr.
- All arithmetic is 32-bit modulo 2^32. `F_pc`=0xFFFF_FFFC with seq gives 0x0000_0000.
- On each non-stalled edge: `F_pc` ← next PC, `D_instr` ← `F_instr`, `D_pc` ← `F_pc`.
- On a stalled edge: `F_pc`, `D_instr` and `D_pc` hold. `npc_sel`, `branch_taken` and `jr_target` are ignored for that edge; the held D instruction re-presents its redirect on the first unstalled edge. Redirects are never lost or applied twice.
- Delay slot: when a redirect is accepted, the instruction fetched in that cycle (at `D_pc + 4`) enters D unconditionally. The target is fetched in the following cycle.
- `PC_RESET` must be word-aligned. `F_pc[1:0]` is always 00.
- Reset values: `F_pc`=`PC_RESET`, `D_instr`=32'h0000_0000 (nop), `D_pc`=`PC_RESET`, `D_pc8`=`PC_RESET`+8.

## Timing
- Latency: an address presented in cycle n appears in `D_instr` / `D_pc` after edge n+1.
- Redirect latency: a branch or jump in D at cycle n produces target fetch at cycle n+1, with the delay slot in D during cycle n+1.
- `stall` and `reset` together: `reset` wins.
- `reset` asserted mid-operation: outputs take reset values asynchronously without waiting for a clock edge. The first fetch after deassertion is at `PC_RESET`.
- `reset` deasserting in the same cycle as `stall`: the edge after deassertion holds `PC_RESET`.
- Combinational paths: `im_addr` and `D_pc8` depend only on registers. The next-PC mux is purely combinational from inputs and registers.

## Test plan
- Reset then free-run with IM holding nops: `F_pc` steps 0x3000, 0x3004, 0x3008. `D_pc` lags by one cycle. `D_instr`=0 immediately after reset.
- Taken branch: `D_pc`=0x3008, `D_instr[15:0]`=0xFFFE, `npc_sel`=01, `branch_taken`=1 → next `F_pc`=0x3004. `D_instr` receives the delay slot from 0x300C.
- Untaken branch with the same setup (`branch_taken`=0) → `F_pc`=0x3010. jal with index 0x0000C10, `D_pc`=0x3000 → `F_pc`=0x3040 and `D_pc8`=0x3008.
- jr with `jr_target`=0x0000_3103 → `F_pc`=0x3100.
- Stall for 3 cycles while a taken branch sits in D: PC and D registers are frozen. The target is loaded exactly once on the first unstalled edge.
- Wrap: force `F_pc`=0xFFFF_FFFC with seq → 0x0000_0000. Assert `reset` asynchronously mid-cycle → `F_pc`=0x3000 before the next edge, and stall during reset has no effect.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - MIPS fetch stage: PC register, next-PC select and F/D pipeline register
module fetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic        branch_taken,
  input  logic [31:0] jr_target,
  input  logic [31:0] F_instr,
  output logic [31:0] im_addr,
  output logic [31:0] F_pc,
  output logic [31:0] D_instr,
  output logic [31:0] D_pc,
  output logic [31:0] D_pc8
);

  localparam logic [1:0] NPC_SEQ    = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;

  logic [31:0] f_pc_q, f_pc_d;
  logic [31:0] d_instr_q;
  logic [31:0] d_pc_q;

  logic [31:0] seq_pc;
  logic [31:0] d_pc4;
  logic [31:0] branch_pc;
  logic [31:0] jump_pc;
  logic [31:0] jr_pc;
  logic [1:0]  unused_jr_low;

  // Targets come from the instruction held in D, so a redirect lands one
  // cycle later and the word fetched alongside it becomes the delay slot.
  assign seq_pc        = f_pc_q + 32'd4;
  assign d_pc4         = d_pc_q + 32'd4;
  assign branch_pc     = d_pc4 + {{14{d_instr_q[15]}}, d_instr_q[15:0], 2'b00};
  assign jump_pc       = {d_pc4[31:28], d_instr_q[25:0], 2'b00};
  assign jr_pc         = {jr_target[31:2], 2'b00};
  assign unused_jr_low = jr_target[1:0];

  always_comb begin
    f_pc_d = seq_pc;
    unique case (npc_sel)
      NPC_SEQ:    f_pc_d = seq_pc;
      NPC_BRANCH: f_pc_d = branch_taken ? branch_pc : seq_pc;
      NPC_JUMP:   f_pc_d = jump_pc;
      default:    f_pc_d = jr_pc;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_pc_q    <= PC_RESET;
      d_instr_q <= 32'h0000_0000;
      d_pc_q    <= PC_RESET;
    end else if (!stall) begin
      f_pc_q    <= f_pc_d;
      d_instr_q <= F_instr;
      d_pc_q    <= f_pc_q;
    end
  end

  assign F_pc    = f_pc_q;
  assign im_addr = f_pc_q;
  assign D_instr = d_instr_q;
  assign D_pc    = d_pc_q;
  assign D_pc8   = d_pc_q + 32'd8;

endmodule
